// File: rtl/lpddr4_cmd_arbiter.sv
// rtl/lpddr4_cmd_arbiter.sv - round-robin DFI command arbiter with tRRD/tFAW/tCCD gating and refresh handoff
module lpddr4_cmd_arbiter #(
  parameter int NUM_BANKS = 8,
  parameter int CFG_W     = 8,
  localparam int IDX_W    = $clog2(NUM_BANKS)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_BANKS-1:0] req_valid,
  input  logic [NUM_BANKS-1:0] req_is_act,
  input  logic [NUM_BANKS-1:0] req_is_cas,
  output logic [NUM_BANKS-1:0] req_ready,
  output logic                 out_valid,
  output logic [IDX_W-1:0]     out_idx,
  input  logic                 out_ready,
  input  logic [CFG_W-1:0]     cfg_trrd,
  input  logic [CFG_W-1:0]     cfg_tccd,
  input  logic [CFG_W-1:0]     cfg_tfaw,
  input  logic                 refresh_req,
  output logic                 refresh_gnt
);

  typedef enum logic [1:0] {ARB, DRAIN, GRANT} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [CFG_W-1:0]     trrd_cnt;
  logic [CFG_W-1:0]     ccd_cnt;
  logic [CFG_W-1:0]     faw [4];

  logic                 act_blk;
  logic                 cas_blk;
  logic [3:0]           faw_busy;
  logic [3:0]           faw_load;
  logic [NUM_BANKS-1:0] elig;
  logic                 found;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W-1:0]     cand;
  logic                 fire;
  logic                 act_fire;
  logic                 cas_fire;

  // A loaded timer of N cycles counts N-1 down to 0, so cfg 0 and 1 both mean "no gap".
  function automatic logic [CFG_W-1:0] sat_dec(input logic [CFG_W-1:0] v);
    return (v == '0) ? '0 : v - CFG_W'(1);
  endfunction

  always_comb begin
    for (int j = 0; j < 4; j++) faw_busy[j] = (faw[j] != '0);
  end

  assign act_blk = (trrd_cnt != '0) | (&faw_busy);
  assign cas_blk = (ccd_cnt != '0);
  assign elig    = req_valid & ~(req_is_act & {NUM_BANKS{act_blk}})
                             & ~(req_is_cas & {NUM_BANKS{cas_blk}});

  // Scan starts one past the last winner so every requester gets its turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_BANKS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_BANKS);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign out_valid = found & (state == ARB) & ~refresh_req & ~sys_rst;
  assign out_idx   = out_valid ? sel : '0;
  assign fire      = out_valid & out_ready;
  assign req_ready = fire ? ({{(NUM_BANKS-1){1'b0}}, 1'b1} << out_idx) : '0;
  assign act_fire  = fire & req_is_act[out_idx];
  assign cas_fire  = fire & req_is_cas[out_idx];

  // Only the lowest idle tFAW slot records a new ACT.
  always_comb begin
    faw_load = '0;
    for (int j = 3; j >= 0; j--) begin
      if (!faw_busy[j]) faw_load = 4'(1) << j;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ARB;
      rr_ptr      <= IDX_W'(NUM_BANKS - 1);
      trrd_cnt    <= '0;
      ccd_cnt     <= '0;
      for (int j = 0; j < 4; j++) faw[j] <= '0;
      refresh_gnt <= 1'b0;
    end else begin
      if (fire) rr_ptr <= out_idx;
      trrd_cnt <= act_fire ? sat_dec(cfg_trrd) : sat_dec(trrd_cnt);
      ccd_cnt  <= cas_fire ? sat_dec(cfg_tccd) : sat_dec(ccd_cnt);
      for (int j = 0; j < 4; j++) begin
        faw[j] <= (act_fire && faw_load[j]) ? sat_dec(cfg_tfaw) : sat_dec(faw[j]);
      end
      case (state)
        ARB: begin
          if (refresh_req) state <= DRAIN;
        end
        DRAIN: begin
          state       <= GRANT;
          refresh_gnt <= 1'b1;
        end
        GRANT: begin
          if (!refresh_req) begin
            state       <= ARB;
            refresh_gnt <= 1'b0;
          end
        end
        default: begin
          state       <= ARB;
          refresh_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr4_cmd_arbiter.sv
// tb/tb_lpddr4_cmd_arbiter.sv - directed vector bench for lpddr4_cmd_arbiter
module tb_lpddr4_cmd_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] req_valid = '0;
  logic [7:0] req_is_act = '0;
  logic [7:0] req_is_cas = '0;
  logic [7:0] req_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_ready = 1'b0;
  logic [7:0] cfg_trrd = '0;
  logic [7:0] cfg_tccd = '0;
  logic [7:0] cfg_tfaw = '0;
  logic       refresh_req = 1'b0;
  logic       refresh_gnt;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  lpddr4_cmd_arbiter #(.NUM_BANKS(8), .CFG_W(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req_valid   (req_valid),
    .req_is_act  (req_is_act),
    .req_is_cas  (req_is_cas),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_ready   (out_ready),
    .cfg_trrd    (cfg_trrd),
    .cfg_tccd    (cfg_tccd),
    .cfg_tfaw    (cfg_tfaw),
    .refresh_req (refresh_req),
    .refresh_gnt (refresh_gnt)
  );

  typedef struct {
    logic       rst;
    logic [7:0] valid;
    logic [7:0] act;
    logic [7:0] cas;
    logic       ordy;
    logic       rreq;
    logic [7:0] trrd;
    logic [7:0] tccd;
    logic [7:0] tfaw;
    logic       ev;
    logic [2:0] eidx;
    logic       egnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [7:0] valid, input logic [7:0] act,
                              input logic [7:0] cas, input logic ordy, input logic rreq,
                              input logic [7:0] trrd, input logic [7:0] tccd, input logic [7:0] tfaw,
                              input logic ev, input logic [2:0] eidx, input logic egnt);
    vec_t v;
    v.rst = rst; v.valid = valid; v.act = act; v.cas = cas; v.ordy = ordy; v.rreq = rreq;
    v.trrd = trrd; v.tccd = tccd; v.tfaw = tfaw; v.ev = ev; v.eidx = eidx; v.egnt = egnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act_v, exp_v);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [7:0] exp_ready;
    @(negedge sys_clk);
    sys_rst     = v.rst;
    req_valid   = v.valid;
    req_is_act  = v.act;
    req_is_cas  = v.cas;
    out_ready   = v.ordy;
    refresh_req = v.rreq;
    cfg_trrd    = v.trrd;
    cfg_tccd    = v.tccd;
    cfg_tfaw    = v.tfaw;
    #1;
    exp_ready = (v.ev && v.ordy) ? (8'h01 << v.eidx) : 8'h00;
    check({tag, " out_valid"},   {7'b0, out_valid},   {7'b0, v.ev});
    check({tag, " out_idx"},     {5'b0, out_idx},     {5'b0, v.eidx});
    check({tag, " req_ready"},   req_ready,           exp_ready);
    check({tag, " refresh_gnt"}, {7'b0, refresh_gnt}, {7'b0, v.egnt});
  endtask

  vec_t tbl[$];

  initial begin
    // reset, then test 1: plain commands rotate 0..7,0
    tbl.push_back(mk(1, 8'hff, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(0, 8'hff, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 3'(i % 8), 0));
    // test 2: tRRD=4 spacing between banks 2 and 5
    tbl.push_back(mk(0, 8'h24, 8'h24, 8'h00, 1, 0, 4, 0, 0, 1, 2, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 8'h20, 8'h20, 8'h00, 1, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h20, 8'h20, 8'h00, 1, 0, 4, 0, 0, 1, 5, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 4, 0, 0, 0, 0, 0));
    // test 3: tFAW=10 holds the fifth ACT
    tbl.push_back(mk(0, 8'h1f, 8'h1f, 8'h00, 1, 0, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 8'h1e, 8'h1e, 8'h00, 1, 0, 1, 0, 10, 1, 1, 0));
    tbl.push_back(mk(0, 8'h1c, 8'h1c, 8'h00, 1, 0, 1, 0, 10, 1, 2, 0));
    tbl.push_back(mk(0, 8'h18, 8'h18, 8'h00, 1, 0, 1, 0, 10, 1, 3, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 8'h10, 8'h10, 8'h00, 1, 0, 1, 0, 10, 0, 0, 0));
    tbl.push_back(mk(0, 8'h10, 8'h10, 8'h00, 1, 0, 1, 0, 10, 1, 4, 0));
    // test 4: tCCD=2, PRE slips between the two CAS
    tbl.push_back(mk(0, 8'h1a, 8'h00, 8'h0a, 1, 0, 1, 2, 10, 1, 1, 0));
    tbl.push_back(mk(0, 8'h18, 8'h00, 8'h08, 1, 0, 1, 2, 10, 1, 4, 0));
    tbl.push_back(mk(0, 8'h08, 8'h00, 8'h08, 1, 0, 1, 2, 10, 1, 3, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 2, 10, 0, 0, 0));
    // backpressure: selection visible, no accept, pointer holds
    tbl.push_back(mk(0, 8'h81, 8'h00, 8'h00, 0, 0, 1, 2, 10, 1, 7, 0));
    tbl.push_back(mk(0, 8'h81, 8'h00, 8'h00, 1, 0, 1, 2, 10, 1, 7, 0));
    tbl.push_back(mk(0, 8'h81, 8'h00, 8'h00, 1, 0, 1, 2, 10, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // test 5: refresh handoff with bank 1 and 2 waiting
    apply(mk(0, 8'h06, 8'h00, 8'h00, 1, 1, 1, 2, 10, 0, 0, 0), "ref_seen");
    apply(mk(0, 8'h06, 8'h00, 8'h00, 1, 1, 1, 2, 10, 0, 0, 0), "ref_drain");
    for (int i = 0; i < 4; i++)
      apply(mk(0, 8'h06, 8'h00, 8'h00, 1, 1, 1, 2, 10, 0, 0, 1), $sformatf("ref_grant%0d", i));
    apply(mk(0, 8'h06, 8'h00, 8'h00, 1, 0, 1, 2, 10, 0, 0, 1), "ref_release");
    apply(mk(0, 8'h06, 8'h00, 8'h00, 1, 0, 1, 2, 10, 1, 1, 0), "ref_resume");

    // test 6: reset while in GRANT with ccd_cnt=3
    apply(mk(0, 8'h04, 8'h00, 8'h04, 1, 0, 1, 6, 10, 1, 2, 0), "rst_cas");
    apply(mk(0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 6, 10, 0, 0, 0), "rst_req");
    apply(mk(0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 6, 10, 0, 0, 0), "rst_drain");
    apply(mk(1, 8'hff, 8'h00, 8'hff, 1, 1, 1, 6, 10, 0, 0, 1), "rst_in_grant");
    apply(mk(0, 8'hff, 8'h00, 8'hff, 1, 0, 1, 6, 10, 1, 0, 0), "rst_after");
    apply(mk(0, 8'hff, 8'h00, 8'hff, 1, 0, 1, 6, 10, 0, 0, 0), "rst_ccd_reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
